// File: rtl/alarm_ctrl.sv
// Alarm sequencer: setpoint register, 1 Hz match against time of day, and the IDLE/ARMED/RINGING/SNOOZE machine.
// Every output is registered and changes one clk after the input that caused it.
module alarm_ctrl #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [4:0] time_hh,
  input  logic [5:0] time_mm,
  input  logic [5:0] time_ss,
  input  logic       arm,
  input  logic       set_alarm,
  input  logic [4:0] set_hh,
  input  logic [5:0] set_mm,
  input  logic       snooze,
  input  logic       stop,
  output logic       ring,
  output logic       gate_en,
  output logic       set_err,
  output logic [1:0] state,
  output logic [4:0] alm_hh,
  output logic [5:0] alm_mm
);

  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNZ_TICKS + 1);
  localparam int UW = (MAX_SNOOZE < 2) ? 1 : $clog2(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] RING_LD  = RW'(RING_SECS);
  localparam logic [SW-1:0] SNZ_LD   = SW'(SNZ_TICKS);
  localparam logic [UW-1:0] USED_MAX = UW'(MAX_SNOOZE);
  localparam logic [RW-1:0] RING_ONE = RW'(1);
  localparam logic [SW-1:0] SNZ_ONE  = SW'(1);
  localparam logic [UW-1:0] USED_ONE = UW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SW-1:0]   snooze_cnt_q, snooze_cnt_d;
  logic [UW-1:0]   snooze_used_q, snooze_used_d;
  logic            ring_q, ring_d;
  logic            gate_en_q, gate_en_d;
  logic            set_err_q, set_err_d;
  logic [4:0]      alm_hh_q, alm_hh_d;
  logic [5:0]      alm_mm_q, alm_mm_d;

  logic set_ok;
  logic match;

  assign set_ok = (set_hh < 5'd24) && (set_mm < 6'd60);
  // Qualifying on the tick and second zero keeps a held time from re-firing.
  assign match  = sec_tick && (time_hh == alm_hh_q) && (time_mm == alm_mm_q) &&
                  (time_ss == 6'd0);

  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snooze_cnt_d  = snooze_cnt_q;
    snooze_used_d = snooze_used_q;
    gate_en_d     = gate_en_q;
    set_err_d     = 1'b0;
    alm_hh_d      = alm_hh_q;
    alm_mm_d      = alm_mm_q;

    if (set_alarm) begin
      if (set_ok) begin
        alm_hh_d = set_hh;
        alm_mm_d = set_mm;
      end else begin
        set_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (match) begin
          state_d       = ST_RINGING;
          ring_cnt_d    = RING_LD;
          snooze_used_d = '0;
          gate_en_d     = 1'b1;
        end
      end
      ST_RINGING: begin
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (stop) begin
          state_d = ST_ARMED;
        end else if (snooze && (snooze_used_q < USED_MAX)) begin
          state_d       = ST_SNOOZE;
          snooze_cnt_d  = SNZ_LD;
          snooze_used_d = snooze_used_q + USED_ONE;
        end else if (sec_tick) begin
          // A snooze refused at the limit falls through so the tick still counts.
          if (ring_cnt_q == RING_ONE) begin
            state_d = ST_ARMED;
          end else begin
            ring_cnt_d = ring_cnt_q - RING_ONE;
            gate_en_d  = ~gate_en_q;
          end
        end
      end
      ST_SNOOZE: begin
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (stop) begin
          state_d = ST_ARMED;
        end else if (sec_tick) begin
          if (snooze_cnt_q == SNZ_ONE) begin
            state_d    = ST_RINGING;
            ring_cnt_d = RING_LD;
            gate_en_d  = 1'b1;
          end else begin
            snooze_cnt_d = snooze_cnt_q - SNZ_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ring_d = (state_d == ST_RINGING);
    if (state_d != ST_RINGING) gate_en_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ring_cnt_q    <= '0;
      snooze_cnt_q  <= '0;
      snooze_used_q <= '0;
      ring_q        <= 1'b0;
      gate_en_q     <= 1'b0;
      set_err_q     <= 1'b0;
      alm_hh_q      <= '0;
      alm_mm_q      <= '0;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snooze_cnt_q  <= snooze_cnt_d;
      snooze_used_q <= snooze_used_d;
      ring_q        <= ring_d;
      gate_en_q     <= gate_en_d;
      set_err_q     <= set_err_d;
      alm_hh_q      <= alm_hh_d;
      alm_mm_q      <= alm_mm_d;
    end
  end

  assign ring    = ring_q;
  assign gate_en = gate_en_q;
  assign set_err = set_err_q;
  assign state   = state_q;
  assign alm_hh  = alm_hh_q;
  assign alm_mm  = alm_mm_q;

endmodule
